// File: rtl/cla_pkg.sv
// cla_pkg: op encoding and group width shared by the pipelined carry-lookahead adder
package cla_pkg;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   localparam int   GRP    = 4;
endpackage

// File: rtl/cla_grp4.sv
// cla_grp4: 4-bit carry-lookahead group producing group generate/propagate and sum
module cla_grp4
   import cla_pkg::*;
(
   input  logic [GRP-1:0] a,
   input  logic [GRP-1:0] b,
   input  logic           ci,
   output logic           g_o,
   output logic           p_o,
   output logic [GRP-1:0] s
);
   logic [GRP-1:0] g, p, c;
   always_comb begin
      g    = a & b;
      p    = a | b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      p_o  = &p;
      s    = a ^ b ^ c;
   end
endmodule

// File: rtl/cla_pipe_add.sv
// cla_pipe_add: two-stage pipelined carry-lookahead adder/subtractor with
// valid/ready on both sides and carry, overflow and zero flags
module cla_pipe_add
   import cla_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic             zero
);
   localparam int NG = WIDTH / GRP;
   if (WIDTH % GRP != 0 || WIDTH < 8 || WIDTH > 32) begin : g_bad_width
      $error("cla_pipe_add: WIDTH must be a multiple of 4 within 8..32");
   end
   logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
   logic [WIDTH-1:0] a_q, a_d, bx_q, bx_d, s_q, s_d, sum;
   logic             cx_q, cx_d, co_q, co_d, ovf_q, ovf_d, zero_q, zero_d;
   logic [NG-1:0]    gg, gp;
   logic [NG:0]      gc;
   logic             s2_load, s1_adv, take, term, acc, c_msb;
   for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_grp4 u_grp (
         .a   (a_q[GRP*k +: GRP]),
         .b   (bx_q[GRP*k +: GRP]),
         .ci  (gc[k]),
         .g_o (gg[k]),
         .p_o (gp[k]),
         .s   (sum[GRP*k +: GRP])
      );
   end
   // Second-level lookahead: each group carry is a flat sum of products, no ripple.
   always_comb begin
      gc    = '0;
      gc[0] = cx_q;
      term  = 1'b0;
      acc   = 1'b0;
      for (int k = 0; k < NG; k++) begin
         term = cx_q;
         for (int j = 0; j <= k; j++) term = term & gp[j];
         acc = term;
         for (int j = 0; j <= k; j++) begin
            term = gg[j];
            for (int m = j + 1; m <= k; m++) term = term & gp[m];
            acc = acc | term;
         end
         gc[k+1] = acc;
      end
   end
   always_comb begin
      s2_load     = ~out_valid_q | out_ready;
      s1_adv      = s1_valid_q & s2_load;
      in_ready    = ~s1_valid_q | s2_load;
      take        = in_valid & in_ready;
      s1_valid_d  = take | (s1_valid_q & ~s2_load);
      a_d         = take ? a : a_q;
      bx_d        = take ? ((op == OP_SUB) ? ~b : b) : bx_q;
      cx_d        = take ? ((op == OP_SUB) ? ~ci : ci) : cx_q;
      out_valid_d = s2_load ? s1_valid_q : out_valid_q;
      c_msb       = a_q[WIDTH-1] ^ bx_q[WIDTH-1] ^ sum[WIDTH-1];
      s_d         = s1_adv ? sum : s_q;
      co_d        = s1_adv ? gc[NG] : co_q;
      ovf_d       = s1_adv ? (gc[NG] ^ c_msb) : ovf_q;
      zero_d      = s1_adv ? ~|sum : zero_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         bx_q        <= '0;
         cx_q        <= 1'b0;
         s_q         <= '0;
         co_q        <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         a_q         <= a_d;
         bx_q        <= bx_d;
         cx_q        <= cx_d;
         s_q         <= s_d;
         co_q        <= co_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
      end
   end
   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign co        = co_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe_add.sv
// tb_cla_pipe_add: scoreboard bench for 32-bit and 8-bit cla_pipe_add instances
module tb_cla_pipe_add;
   logic        clk = 1'b0, reset_n = 1'b0;
   always #5 clk = ~clk;
   logic        in_valid = 1'b0, ci = 1'b0, op = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, co, ovf, zero;
   logic [31:0] a = '0, b = '0, s;
   logic        in_valid8 = 1'b0, ci8 = 1'b0, op8 = 1'b0, out_ready8 = 1'b1;
   logic        in_ready8, out_valid8, co8, ovf8, zero8;
   logic [7:0]  a8 = '0, b8 = '0, s8;
   int          pass = 0, total = 0;
   logic [34:0] exp_q[$];
   logic [10:0] exp8_q[$];

   cla_pipe_add #(.WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .ovf(ovf), .zero(zero));

   cla_pipe_add #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .ci(ci8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
      .s(s8), .co(co8), .ovf(ovf8), .zero(zero8));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act === req) pass++;
      else $display("FAIL %s: got %h want %h", nm, act, req);
   endtask

   // expected words are {co, ovf, zero, s}
   task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                       input logic top, input logic [34:0] e);
      logic rdy;
      int   n = 0;
      a = ta; b = tb; ci = tci; op = top; in_valid = 1'b1;
      do begin
         @(negedge clk) rdy = in_ready;
         @(posedge clk) n++;
      end while (!rdy && n < 50);
      chk("accept32", rdy, 1);
      if (rdy) exp_q.push_back(e);
      #1 in_valid = 1'b0;
   endtask

   task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                        input logic top, input logic [10:0] e);
      logic rdy;
      int   n = 0;
      a8 = ta; b8 = tb; ci8 = tci; op8 = top; in_valid8 = 1'b1;
      do begin
         @(negedge clk) rdy = in_ready8;
         @(posedge clk) n++;
      end while (!rdy && n < 50);
      chk("accept8", rdy, 1);
      if (rdy) exp8_q.push_back(e);
      #1 in_valid8 = 1'b0;
   endtask

   // Output must match the queue head every valid cycle, so stalled outputs are checked for stability.
   always @(negedge clk) begin
      if (reset_n && out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL spurious32: got s=%h with no result outstanding", s);
         end else begin
            chk("result32", {co, ovf, zero, s}, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
      if (reset_n && out_valid8) begin
         if (exp8_q.size() == 0) begin
            total++;
            $display("FAIL spurious8: got s=%h with no result outstanding", s8);
         end else begin
            chk("result8", {co8, ovf8, zero8, s8}, exp8_q[0]);
            if (out_ready8) void'(exp8_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #2;
      chk("rst out_valid", out_valid, 0);
      chk("rst in_ready", in_ready, 1);
      chk("rst s/flags", {co, ovf, zero, s}, 0);
      #10 reset_n = 1'b1;
      @(posedge clk) #1;
      send(32'hFFFF_FFFF, 32'h1, 0, 0, {3'b101, 32'h0});
      chk("latency edge N", out_valid, 0);
      @(posedge clk) #1;
      chk("latency edge N+1", out_valid, 1);
      send(32'h8000_0000, 32'h1, 0, 1, {3'b110, 32'h7FFF_FFFF});
      send(32'h1, 32'h2, 0, 0, {3'b000, 32'h3});
      send(32'h3, 32'h4, 0, 0, {3'b000, 32'h7});
      send(32'h7FFF_FFFF, 32'h1, 0, 0, {3'b010, 32'h8000_0000});
      send(32'h5, 32'h0, 1, 0, {3'b000, 32'h6});
      send(32'hA, 32'h3, 1, 1, {3'b100, 32'h6});
      out_ready = 1'b0;
      fork
         begin
            send(32'd10, 32'd20, 0, 0, {3'b000, 32'd30});
            send(32'd100, 32'd1, 0, 0, {3'b000, 32'd101});
            send(32'd50, 32'd8, 0, 1, {3'b100, 32'd42});
            send(32'd0, 32'd0, 0, 0, {3'b001, 32'd0});
            send(32'd5, 32'd7, 0, 1, {3'b000, 32'hFFFF_FFFE});
         end
         begin
            repeat (4) @(negedge clk);
            chk("stall in_ready", in_ready, 0);
            chk("stall out_valid", out_valid, 1);
            @(posedge clk) #1 out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1 chk("drain32", exp_q.size(), 0);
      out_ready = 1'b0;
      send(32'h11, 32'h22, 0, 0, {3'b000, 32'h33});
      send(32'h44, 32'h55, 0, 0, {3'b000, 32'h99});
      #2 reset_n = 1'b0;
      #1;
      chk("reset out_valid", out_valid, 0);
      chk("reset in_ready", in_ready, 1);
      exp_q.delete();
      exp8_q.delete();
      @(negedge clk);
      @(negedge clk) reset_n = 1'b1;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("post-reset idle", out_valid, 0);
      send8(8'h7F, 8'h01, 0, 0, {3'b010, 8'h80});
      send8(8'h00, 8'h01, 0, 1, {3'b000, 8'hFF});
      send8(8'hFF, 8'h01, 0, 0, {3'b101, 8'h00});
      repeat (4) @(posedge clk);
      #1 chk("drain8", exp8_q.size(), 0);
      chk("drain32 final", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
